cube_target_check: RTL

CUBE_TARGET_CHECK -- requirements
Module: cube_target_check

---
 rtl/cube_target_check.sv | 97 +++++++++
 1 files changed

// File: rtl/cube_target_check.sv
// cube512 share check: compares the hash's top 64-bit word against the target
// and queues matching nonces in a small result FIFO.
module cube_target_check #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [511:0] in_hash,
  input  logic [31:0]  in_nonce,
  input  logic [63:0]  target,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_nonce,
  output logic [63:0]  out_word,
  output logic [31:0]  hash_count,
  output logic [15:0]  drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic        s1_valid;
  logic [31:0] s1_nonce;
  logic [63:0] s1_word;
  logic [63:0] s1_target;
  logic        s2_match;
  logic [31:0] s2_nonce;
  logic [63:0] s2_word;

  logic [31:0] mem_nonce [FIFO_DEPTH];
  logic [63:0] mem_word  [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic full;
  logic pop;
  logic push;
  logic drop;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign push      = s2_match && (!full || pop);
  assign drop      = s2_match && full && !pop;

  assign out_nonce = out_valid ? mem_nonce[rd_ptr] : '0;
  assign out_word  = out_valid ? mem_word[rd_ptr]  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_nonce   <= '0;
      s1_word    <= '0;
      s1_target  <= '0;
      s2_match   <= 1'b0;
      s2_nonce   <= '0;
      s2_word    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      hash_count <= '0;
      drop_count <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_nonce  <= in_nonce;
      s1_word   <= in_hash[511:448];
      s1_target <= target;
      s2_match  <= s1_valid && (s1_word <= s1_target);
      s2_nonce  <= s1_nonce;
      s2_word   <= s1_word;
      if (in_valid)
        hash_count <= hash_count + 32'd1;
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_nonce[wr_ptr] <= s2_nonce;
      mem_word[wr_ptr]  <= s2_word;
    end
  end

endmodule
